// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
//   WORD_W           : PC / instruction word width
//   OPC_MSB/OPC_LSB  : opcode field position inside an instruction word
//   fetch_state_e    : fetch controller states
package fetch_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller for the 16-bit pipelined core.
// Requests one instruction at a time from a variable-latency instruction
// memory, presents it to IF/ID over valid/ready, advances the PC register
// and handles branch redirects and the halt opcode.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_current               PC register value
//   pc_new, pc_wen           next PC value and its write enable
//   imem_req, imem_addr      one-cycle read request and address
//   imem_valid, imem_data    read response
//   redirect, redirect_pc    taken branch/jump from EX and its target
//   instr_valid/ready        handshake to IF/ID
//   instr, instr_pc          presented instruction and its address
//   stall_cnt                stall cycle counter (FETCH_CTRL_PERF_CNT_EN only)
//   halted                   fetch stopped on HALT_OPC
//
// Build option: define FETCH_CTRL_PERF_CNT_EN to add the saturating
// stall_cnt output (cycles in WAIT plus back-pressured cycles in HOLD).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] PC_INC   = 16'd2,
  parameter logic [3:0]        HALT_OPC = 4'hF,
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc_current,
  output logic [WORD_W-1:0] pc_new,
  output logic              pc_wen,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
`ifdef FETCH_CTRL_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              halted
);

  fetch_state_e      state, state_nxt;
  logic              drop_q, drop_nxt;
  logic [WORD_W-1:0] req_pc_q;
  logic              capture, clr_valid, set_halted, clr_halted;

  assign imem_addr = pc_current;

  always_comb begin
    state_nxt  = state;
    drop_nxt   = drop_q;
    pc_new     = pc_current;
    pc_wen     = 1'b0;
    imem_req   = 1'b0;
    capture    = 1'b0;
    clr_valid  = 1'b0;
    set_halted = 1'b0;
    clr_halted = 1'b0;
    if (rst) begin
      pc_new = RESET_PC;
      pc_wen = 1'b1;
    end else if (redirect) begin
      // No request is issued in a redirect cycle: its address would be stale.
      pc_new     = redirect_pc;
      pc_wen     = 1'b1;
      clr_valid  = 1'b1;
      clr_halted = 1'b1;
      state_nxt  = FETCH_REQ;
      if (state == FETCH_WAIT) begin
        // A response arriving in this cycle is simply discarded; otherwise
        // the one still in flight must be swallowed when it turns up.
        drop_nxt = !imem_valid;
        if (!imem_valid) begin
          state_nxt = FETCH_WAIT;
        end
      end
    end else begin
      unique case (state)
        FETCH_REQ: begin
          imem_req  = 1'b1;
          state_nxt = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem_valid) begin
            if (drop_q) begin
              drop_nxt  = 1'b0;
              state_nxt = FETCH_REQ;
            end else begin
              capture   = 1'b1;
              pc_new    = req_pc_q + PC_INC;
              pc_wen    = 1'b1;
              state_nxt = (imem_data[OPC_MSB:OPC_LSB] == HALT_OPC) ? FETCH_HALT
                                                                   : FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (instr_ready) begin
            clr_valid = 1'b1;
            state_nxt = FETCH_REQ;
          end
        end
        FETCH_HALT: begin
          if (instr_valid && instr_ready) begin
            clr_valid  = 1'b1;
            set_halted = 1'b1;
          end
        end
        default: state_nxt = FETCH_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_REQ;
      drop_q      <= 1'b0;
      req_pc_q    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      state  <= state_nxt;
      drop_q <= drop_nxt;
      if (imem_req) begin
        req_pc_q <= pc_current;
      end
      if (capture) begin
        instr       <= imem_data;
        instr_pc    <= req_pc_q;
        instr_valid <= 1'b1;
      end else if (clr_valid) begin
        instr_valid <= 1'b0;
      end
      if (clr_halted) begin
        halted <= 1'b0;
      end else if (set_halted) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (((state == FETCH_WAIT) || (state == FETCH_HOLD && !instr_ready))
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_current;
  logic [15:0] pc_new;
  logic        pc_wen;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        halted;
`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(
    .PC_INC(16'd2),
    .HALT_OPC(4'hF),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_current(pc_current),
    .pc_new(pc_new),
    .pc_wen(pc_wen),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_valid(imem_valid),
    .imem_data(imem_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
`ifdef FETCH_CTRL_PERF_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .halted(halted)
  );

  // PC register owned by the surrounding core
  logic [15:0] pc_reg;
  always_ff @(posedge clk) begin
    if (pc_wen) pc_reg <= pc_new;
  end
  assign pc_current = pc_reg;

  int          checks = 0;
  int          failures = 0;
  int          n_accepted = 0;
  logic [15:0] exp_next_addr = 16'h0000;
  bit          exp_halt = 1'b0;
  bit          squash_inflight = 1'b0;
  bit          halt_en = 1'b0;
  bit          lat_rand = 1'b0;
  int unsigned lat_fixed = 1;
  logic [31:0] sb[$];

  // Program image: ordinary words never carry the halt opcode.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [14:0] h;
    if (halt_en && a == 16'h0010) return 16'hF000;
    h = (a[15:1] * 15'd37) ^ 15'h2C91;
    return {1'b0, h};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: answers each request after a chosen latency.
  initial begin
    logic [15:0] a;
    int unsigned l;
    imem_valid = 1'b0;
    imem_data  = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1 && rst === 1'b0) begin
        a = imem_addr;
        l = lat_rand ? $urandom_range(1, 4) : lat_fixed;
        repeat (l) @(posedge clk);
        #1;
        imem_valid = 1'b1;
        imem_data  = mem_word(a);
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [15:0] inflight_a;
    logic [15:0] w;
    logic [31:0] e;
    bit          pv, prdy, predir;
    logic [15:0] pinstr, ppc;
    inflight_a = '0;
    pv = 0; prdy = 0; predir = 0; pinstr = '0; ppc = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        pv = 0;
      end else begin
        if (imem_req) begin
          chk(imem_addr === exp_next_addr, "imem_addr", imem_addr, exp_next_addr);
          chk(!exp_halt, "req_after_halt", imem_addr, 0);
          chk(sb.size() == 0, "req_overlap", sb.size(), 0);
          inflight_a    = exp_next_addr;
          exp_next_addr = exp_next_addr + 16'd2;
        end
        if (imem_valid) begin
          if (squash_inflight) begin
            squash_inflight = 1'b0;
            if (!redirect) chk(pc_wen === 1'b0, "drop_pc_wen", pc_wen, 0);
          end else begin
            w = mem_word(inflight_a);
            sb.push_back({w, inflight_a});
            if (w[15:12] == 4'hF) exp_halt = 1'b1;
            chk(pc_wen === 1'b1 && pc_new === inflight_a + 16'd2, "capture_pc_new",
                {15'd0, pc_wen, pc_new}, {16'd1, inflight_a + 16'd2});
          end
        end else if (!redirect) begin
          chk(pc_wen === 1'b0, "idle_pc_wen", pc_wen, 0);
        end
        if (pv && !prdy && !predir) begin
          chk(instr_valid === 1'b1 && instr === pinstr && instr_pc === ppc, "hold_stable",
              {instr, instr_pc}, {pinstr, ppc});
        end
        if (pv && (prdy || predir)) begin
          chk(instr_valid === 1'b0, "valid_drop", instr_valid, 0);
        end
        if (instr_valid && instr_ready && !redirect) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_instr", {instr, instr_pc}, 0);
          end else begin
            e = sb.pop_front();
            chk({instr, instr_pc} === e, "instr_pc", {instr, instr_pc}, e);
          end
          n_accepted++;
        end
        pv = instr_valid; prdy = instr_ready; predir = redirect;
        pinstr = instr; ppc = instr_pc;
      end
    end
  end

  task automatic wait_accepts(input int n, input bit rnd, input int budget);
    int target;
    target = n_accepted + n;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n_accepted >= target) return;
    end
    chk(1'b0, "accept_timeout", n_accepted, target);
  endtask

  // Park on a presented instruction and squash it with a redirect.
  task automatic redirect_hold(input logic [15:0] tgt);
    bit seen;
    instr_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = instr_valid;
    end
    chk(seen, "hold_timeout", 0, 1);
    @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = tgt;
    chk(sb.size() == 1, "squash_entry", sb.size(), 1);
    if (sb.size() > 0) void'(sb.pop_back());
    exp_next_addr = tgt;
    exp_halt = 1'b0;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  // Redirect in the cycle after a request: its response must be dropped.
  task automatic redirect_wait(input logic [15:0] tgt);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    chk(seen, "req_timeout", 0, 1);
    @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = tgt;
    squash_inflight = 1'b1;
    exp_next_addr = tgt;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(pc_wen === 1'b1, "rst_pc_wen", pc_wen, 1);
    chk(pc_new === 16'h0000, "rst_pc_new", pc_new, 16'h0000);
    chk(imem_req === 1'b0, "rst_imem_req", imem_req, 0);
    chk(instr_valid === 1'b0, "rst_instr_valid", instr_valid, 0);
    chk(halted === 1'b0, "rst_halted", halted, 0);
    chk({instr, instr_pc} === 32'h0, "rst_instr", {instr, instr_pc}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sequential stream, latency 1, always ready
    lat_rand = 1'b0;
    lat_fixed = 1;
    wait_accepts(3, 1'b0, 60);
    // Random latency and back-pressure
    lat_rand = 1'b1;
    wait_accepts(20, 1'b1, 2000);

    // Redirects during WAIT: in-flight and simultaneous response
    lat_rand = 1'b0;
    lat_fixed = 3;
    redirect_wait(16'h0100);
    wait_accepts(2, 1'b1, 200);
    lat_fixed = 1;
    redirect_wait(16'h0200);
    wait_accepts(2, 1'b1, 200);

    // Halt at 0x0010, then resume via redirect
    lat_rand = 1'b1;
    halt_en = 1'b1;
    redirect_hold(16'h000C);
    wait_accepts(3, 1'b1, 300);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = halted;
    end
    chk(seen, "halted_set", halted, 1);
    repeat (20) @(negedge clk);
    chk(halted === 1'b1 && instr_valid === 1'b0, "halt_idle",
        {halted, instr_valid}, 2'b10);
    @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    exp_next_addr = 16'h0020;
    exp_halt = 1'b0;
    halt_en = 1'b0;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk(halted === 1'b0, "halted_clear", halted, 0);
    wait_accepts(2, 1'b1, 200);

    // PC wrap 0xFFFE -> 0x0000
    redirect_hold(16'hFFFC);
    wait_accepts(3, 1'b1, 300);

`ifdef FETCH_CTRL_PERF_CNT_EN
    begin
      logic [15:0] c0;
      lat_rand = 1'b0;
      lat_fixed = 3;
      redirect_hold(16'h0300);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = imem_req;
      end
      c0 = stall_cnt;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = instr_valid;
      end
      chk(seen, "perf_valid", 0, 1);
      @(posedge clk); #1; instr_ready = 1'b0;
      @(posedge clk); #1; instr_ready = 1'b1;
      @(posedge clk); #1; instr_ready = 1'b0;
      @(negedge clk);
      chk(stall_cnt === c0 + 16'd5, "stall_cnt", stall_cnt, c0 + 16'd5);
    end
`endif

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
